// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM encoding
// and the result width.
package alu_pkg;

  localparam int RES_W = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_bit_8.sv
// Combinational 8-bit ALU with a 16-bit result; operands are zero-extended
// and shifts only look at the low three bits of b.
module ALU_bit_8
  import alu_pkg::*;
(
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [2:0]       op,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {8'h00, a};
  assign b_ext = {8'h00, b};

  // Opcode decode; the 16-bit width makes subtraction wrap naturally.
  always_comb begin
    result = 16'h0000;
    case (op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_MUL:  result = a_ext * b_ext;
      OP_SHL:  result = a_ext << b[2:0];
      OP_SHR:  result = a_ext >> b[2:0];
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      default: result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_8.sv
// Round-robin arbiter sharing one ALU_bit_8 between two requesters, with a
// captured command, optional multiply stall and a held response channel.
module alu_arbiter_8
  import alu_pkg::*;
#(
  parameter int unsigned MUL_STALL = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [7:0]       Req0A,
  input  logic [7:0]       Req0B,
  input  logic [2:0]       Req0Op,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [7:0]       Req1A,
  input  logic [7:0]       Req1B,
  input  logic [2:0]       Req1Op,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [RES_W-1:0] RspData,
  output logic             RspId,
  output logic             Busy
);

  localparam logic [2:0] STALL_LOAD = 3'(MUL_STALL);

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             win_any;
  logic             win_id;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_id;
  logic [2:0]       stall_cnt;
  logic [RES_W-1:0] alu_result;

  // The ALU only ever sees the captured command, never live requester inputs.
  ALU_bit_8 u_alu (
    .a      (cmd_a),
    .b      (cmd_b),
    .op     (cmd_op),
    .result (alu_result)
  );

  // Arbitration: a lone requester wins; on contention the pointer decides.
  always_comb begin
    win_any = Req0Valid | Req1Valid;
    if (Req0Valid && Req1Valid) begin
      win_id = ptr;
    end else if (Req1Valid) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (win_any) state_next = EXEC;
        else         state_next = IDLE;
      end
      EXEC: begin
        if (stall_cnt == 3'd0) state_next = RESP;
        else                   state_next = EXEC;
      end
      RESP: begin
        if (RspReady) state_next = IDLE;
        else          state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; Ready is only offered to the winner while idle.
  always_comb begin
    Req0Ready = (state == IDLE) && win_any && (win_id == 1'b0);
    Req1Ready = (state == IDLE) && win_any && (win_id == 1'b1);
    RspValid  = (state == RESP);
    Busy      = (state != IDLE);
  end

  // Command capture, stall countdown, result register and pointer update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr       <= 1'b0;
      cmd_a     <= 8'h00;
      cmd_b     <= 8'h00;
      cmd_op    <= 3'd0;
      cmd_id    <= 1'b0;
      stall_cnt <= 3'd0;
      RspData   <= 16'h0000;
      RspId     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            cmd_a     <= win_id ? Req1A : Req0A;
            cmd_b     <= win_id ? Req1B : Req0B;
            cmd_op    <= win_id ? Req1Op : Req0Op;
            cmd_id    <= win_id;
            stall_cnt <= ((win_id ? Req1Op : Req0Op) == OP_MUL) ? STALL_LOAD : 3'd0;
          end
        end
        EXEC: begin
          if (stall_cnt != 3'd0) begin
            stall_cnt <= stall_cnt - 3'd1;
          end else begin
            RspData <= alu_result;
            RspId   <= cmd_id;
          end
        end
        RESP: begin
          if (RspReady) ptr <= ~cmd_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_8.sv
// Directed bench for alu_arbiter_8: two instances (multiply stall 1 and 3)
// share stimulus and are compared every cycle against a transaction model.
module tb_alu_arbiter_8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0Valid = 1'b0, Req1Valid = 1'b0, RspReady = 1'b1;
  logic [7:0]  Req0A = 8'h00, Req0B = 8'h00, Req1A = 8'h00, Req1B = 8'h00;
  logic [2:0]  Req0Op = 3'd0, Req1Op = 3'd0;
  logic [1:0]  o_r0, o_r1, o_v, o_id, o_busy;
  logic [15:0] o_d [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int m_phase [2] = '{0, 0};
  int m_wait  [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};
  int m_id    [2] = '{0, 0};
  int m_data  [2] = '{0, 0};
  int c_res   [2] = '{0, 0};
  int c_id    [2] = '{0, 0};
  int stall   [2] = '{1, 3};
  int win;

  always #5 Clock = ~Clock;

  alu_arbiter_8 #(.MUL_STALL(1)) dut_a (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(o_r0[0]), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
    .Req1Valid(Req1Valid), .Req1Ready(o_r1[0]), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
    .RspValid(o_v[0]), .RspReady(RspReady), .RspData(o_d[0]), .RspId(o_id[0]), .Busy(o_busy[0])
  );

  alu_arbiter_8 #(.MUL_STALL(3)) dut_b (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(o_r0[1]), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
    .Req1Valid(Req1Valid), .Req1Ready(o_r1[1]), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
    .RspValid(o_v[1]), .RspReady(RspReady), .RspData(o_d[1]), .RspId(o_id[1]), .Busy(o_busy[1])
  );

  function automatic int alu(input int a, input int b, input int op);
    case (op)
      0: return a + b;
      1: return (a - b) & 'hFFFF;
      2: return a * b;
      3: return (a << (b % 8)) & 'hFFFF;
      4: return a >> (b % 8);
      5: return a & b;
      6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a command is answered 1+stall cycles after acceptance and held until taken.
  always @(posedge Clock) begin
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        m_phase[k] = 0; m_ptr[k] = 0; m_data[k] = 0; m_id[k] = 0;
      end else begin
        case (m_phase[k])
          0: begin
            win = -1;
            if (Req0Valid && Req1Valid) win = m_ptr[k];
            else if (Req0Valid)         win = 0;
            else if (Req1Valid)         win = 1;
            if (win == 0) begin
              c_res[k] = alu(Req0A, Req0B, Req0Op); c_id[k] = 0;
              m_wait[k] = 1 + ((Req0Op == 3'd2) ? stall[k] : 0); m_phase[k] = 1;
            end else if (win == 1) begin
              c_res[k] = alu(Req1A, Req1B, Req1Op); c_id[k] = 1;
              m_wait[k] = 1 + ((Req1Op == 3'd2) ? stall[k] : 0); m_phase[k] = 1;
            end
          end
          1: begin
            m_wait[k] = m_wait[k] - 1;
            if (m_wait[k] == 0) begin
              m_phase[k] = 2; m_data[k] = c_res[k]; m_id[k] = c_id[k];
            end
          end
          default: begin
            if (RspReady) begin
              m_phase[k] = 0; m_ptr[k] = 1 - m_id[k];
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("req0_ready[%0d]", k), o_r0[k],
              (m_phase[k] == 0 && Req0Valid && (!Req1Valid || m_ptr[k] == 0)) ? 1 : 0);
        check($sformatf("req1_ready[%0d]", k), o_r1[k],
              (m_phase[k] == 0 && Req1Valid && (!Req0Valid || m_ptr[k] == 1)) ? 1 : 0);
        check($sformatf("rsp_valid[%0d]", k), o_v[k], (m_phase[k] == 2) ? 1 : 0);
        check($sformatf("busy[%0d]", k), o_busy[k], (m_phase[k] != 0) ? 1 : 0);
        check($sformatf("rsp_data[%0d]", k), o_d[k], m_data[k]);
        check($sformatf("rsp_id[%0d]", k), o_id[k], m_id[k]);
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (!o_busy[0] && !o_busy[1]) break;
    end
    if (i == 40) check("wait_idle_timeout", 0, 1);
  endtask

  task automatic send(input int who, input int a, input int b, input int op);
    int i;
    wait_idle();
    @(posedge Clock); #1;
    if (who == 0) begin Req0Valid = 1'b1; Req0A = 8'(a); Req0B = 8'(b); Req0Op = 3'(op); end
    else          begin Req1Valid = 1'b1; Req1A = 8'(a); Req1B = 8'(b); Req1Op = 3'(op); end
    for (i = 0; i < 40; i++) begin
      @(negedge Clock);
      if ((who == 0) ? o_r0[0] : o_r1[0]) break;
    end
    if (i == 40) check("send_timeout", 0, 1);
    @(posedge Clock); #1;
    if (who == 0) Req0Valid = 1'b0;
    else          Req1Valid = 1'b0;
  endtask

  // Called just after the handshake edge; n = cycles from handshake cycle to first RspValid minus 1.
  task automatic wait_both(output int n [2], output int d [2], output int id [2]);
    bit got [2];
    int i;
    got = '{1'b0, 1'b0};
    n = '{-1, -1}; d = '{0, 0}; id = '{0, 0};
    for (i = 1; i <= 60; i++) begin
      @(negedge Clock);
      for (int k = 0; k < 2; k++) begin
        if (o_v[k] && !got[k]) begin
          got[k] = 1'b1; n[k] = i - 1; d[k] = o_d[k]; id[k] = o_id[k];
        end
      end
      if (got[0] && got[1]) break;
    end
    if (!(got[0] && got[1])) check("wait_rsp_timeout", 0, 1);
  endtask

  int n [2];
  int d [2];
  int id [2];

  initial begin
    @(posedge Clock); #1;
    chk_en = 1'b1;
    @(negedge Clock);
    check("reset_valid", o_v[0], 0);
    check("reset_busy", o_busy[0], 0);
    check("reset_data", o_d[0], 16'h0000);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Arbitration from reset: both valid, requester 0 wins first.
    Req0A = 8'h81; Req0B = 8'h0B; Req0Op = 3'd3;
    Req1A = 8'h80; Req1B = 8'h07; Req1Op = 3'd4;
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    @(negedge Clock);
    check("arb_first_r0", o_r0[0], 1);
    check("arb_first_r1", o_r1[0], 0);
    @(posedge Clock); #1;
    Req0Valid = 1'b0;
    wait_both(n, d, id);
    check("arb_rsp1_id", id[0], 0);
    check("arb_rsp1_data", d[0], 16'h0408);
    check("arb_rsp1_lat", n[0], 1);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Req1Valid = 1'b0;
    wait_both(n, d, id);
    check("arb_rsp2_id", id[0], 1);
    check("arb_rsp2_data", d[0], 16'h0001);

    // Single requesters.
    send(0, 200, 100, 0);
    wait_both(n, d, id);
    check("add_data", d[0], 16'd300);
    check("add_id", id[0], 0);
    check("add_lat", n[0], 1);
    send(1, 5, 10, 1);
    wait_both(n, d, id);
    check("sub_data", d[0], 16'hFFFB);
    check("sub_id", id[0], 1);

    // Multiply latency with stall 1 and stall 3.
    send(0, 255, 255, 2);
    wait_both(n, d, id);
    check("mul_data_s1", d[0], 16'hFE01);
    check("mul_lat_s1", n[0], 2);
    check("mul_data_s3", d[1], 16'hFE01);
    check("mul_lat_s3", n[1], 4);

    // Backpressure: response held five cycles, taken on the sixth.
    wait_idle();
    @(posedge Clock); #1;
    RspReady = 1'b0;
    send(0, 7, 9, 0);
    wait_both(n, d, id);
    check("bp_lat", n[0], 1);
    @(posedge Clock); #1;
    Req1A = 8'd3; Req1B = 8'd4; Req1Op = 3'd7; Req1Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("bp_hold_valid", o_v[0], 1);
      check("bp_hold_data", o_d[0], 16'd16);
      check("bp_hold_id", o_id[0], 0);
      check("bp_hold_r1", o_r1[0], 0);
      check("bp_hold_busy", o_busy[0], 1);
    end
    @(posedge Clock); #1;
    RspReady = 1'b1;
    @(negedge Clock);
    check("bp_take_valid", o_v[0], 1);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("bp_next_r1", o_r1[0], 1);
    check("bp_next_busy", o_busy[0], 0);
    @(posedge Clock); #1;
    Req1Valid = 1'b0;
    wait_both(n, d, id);
    check("bp_second_data", d[0], 16'd7);
    check("bp_second_id", id[0], 1);

    // Serve requester 0 so the pointer favours 1, then reset mid-multiply.
    send(0, 10, 20, 0);
    wait_both(n, d, id);
    check("pre_rst_data", d[0], 16'd30);
    send(0, 255, 255, 2);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_busy", o_busy[0], 0);
    check("rst_valid", o_v[0], 0);
    check("rst_busy_s3", o_busy[1], 0);
    @(posedge Clock); #1;
    Req0A = 8'd1; Req0B = 8'd2; Req0Op = 3'd0;
    Req1A = 8'd9; Req1B = 8'd1; Req1Op = 3'd1;
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    @(negedge Clock);
    check("post_rst_r0", o_r0[0], 1);
    check("post_rst_r1", o_r1[0], 0);
    @(posedge Clock); #1;
    Req0Valid = 1'b0;
    wait_both(n, d, id);
    check("post_rst_id", id[0], 0);
    check("post_rst_data", d[0], 16'd3);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Req1Valid = 1'b0;
    wait_both(n, d, id);
    check("post_rst2_id", id[0], 1);
    check("post_rst2_data", d[0], 16'd8);

    wait_idle();
    repeat (2) @(posedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
